// File: rtl/retire_store_drain_if.sv
// Data-memory write port of the retire store drain.
// Master issues write requests; slave accepts them and acknowledges completion.
interface retire_store_drain_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic                    mem_resp_valid;

  modport master (
    output mem_req_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_req_ready,
    input  mem_resp_valid
  );

  modport slave (
    input  mem_req_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_req_ready,
    output mem_resp_valid
  );
endinterface

// File: rtl/retire_store_drain.sv
// Retire-side store drain: queues committed store IDs and writes
// each one to data memory in order, one transaction at a time.
module retire_store_drain #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STORE_ID_WIDTH = 4,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          retire_store_valid,
  input  logic [STORE_ID_WIDTH-1:0]     retire_store_id,
  output logic                          drain_full,
  output logic [STORE_ID_WIDTH-1:0]     sq_rd_id,
  input  logic [ADDR_WIDTH-1:0]         sq_rd_addr,
  input  logic [DATA_WIDTH-1:0]         sq_rd_data,
  input  logic [DATA_WIDTH/8-1:0]       sq_rd_strb,
  retire_store_drain_if.master          mem,
  output logic                          sq_release_valid,
  output logic [STORE_ID_WIDTH-1:0]     sq_release_id,
  output logic [$clog2(FIFO_DEPTH):0]   drain_count,
  output logic                          drain_idle,
  output logic                          overflow_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [STORE_ID_WIDTH-1:0] ids_q [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q;
  logic [PW-1:0]             rd_ptr_q;
  logic [CW-1:0]             count_q;

  logic                      req_valid_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [SW-1:0]             wstrb_q;
  logic                      rel_valid_q;
  logic [STORE_ID_WIDTH-1:0] rel_id_q;
  logic                      ovf_q;

  logic full;
  logic push;
  logic pop;
  logic drop;
  logic capture;
  logic accept;

  // Committed stores are architectural; flush is intentionally ignored.
  logic unused_flush;
  assign unused_flush = flush;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign sq_rd_id = ids_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push at full is legal then.
  assign push = retire_store_valid && (!full || pop);
  assign drop = retire_store_valid && full && !pop;

  assign accept = (state_q == REQ) && mem.mem_req_ready;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Skip capture while releasing so the store queue can update.
        if (count_q != '0 && !rel_valid_q) begin
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem.mem_req_ready) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (mem.mem_resp_valid) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) ids_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        ids_q[wr_ptr_q] <= retire_store_id;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else if (capture) begin
      req_valid_q <= 1'b1;
      addr_q      <= sq_rd_addr;
      wdata_q     <= sq_rd_data;
      wstrb_q     <= sq_rd_strb;
    end else if (accept) begin
      req_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_valid_q <= 1'b0;
      rel_id_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      rel_valid_q <= pop;
      if (pop) rel_id_q <= sq_rd_id;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_wstrb     = wstrb_q;

  assign drain_full       = full;
  assign sq_release_valid = rel_valid_q;
  assign sq_release_id    = rel_id_q;
  assign drain_count      = count_q;
  assign drain_idle       = (count_q == '0) && (state_q == IDLE);
  assign overflow_err     = ovf_q;

endmodule

// File: tb/tb_retire_store_drain.sv
// Directed bench for retire_store_drain: single store, stalls,
// ordering, full/overflow, flush and mid-transaction reset.
module tb_retire_store_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        rsv = 1'b0;
  logic [3:0]  rsid = '0;
  logic        drain_full;
  logic [3:0]  sq_rd_id;
  logic [31:0] sq_rd_addr;
  logic [31:0] sq_rd_data;
  logic [3:0]  sq_rd_strb;
  logic        sq_release_valid;
  logic [3:0]  sq_release_id;
  logic [4:0]  drain_count;
  logic        drain_idle;
  logic        overflow_err;
  logic [31:0] salt = '0;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc   = 0;
  int peak  = 0;
  logic [3:0] rel_q [$];
  int         rel_t [$];

  retire_store_drain_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

  retire_store_drain dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush              (flush),
    .retire_store_valid (rsv),
    .retire_store_id    (rsid),
    .drain_full         (drain_full),
    .sq_rd_id           (sq_rd_id),
    .sq_rd_addr         (sq_rd_addr),
    .sq_rd_data         (sq_rd_data),
    .sq_rd_strb         (sq_rd_strb),
    .mem                (mem_if.master),
    .sq_release_valid   (sq_release_valid),
    .sq_release_id      (sq_release_id),
    .drain_count        (drain_count),
    .drain_idle         (drain_idle),
    .overflow_err       (overflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_addr(logic [3:0] id);
    return (id == 4'd3) ? 32'h1000 : 32'h2000 + {24'h0, id, 4'h0};
  endfunction

  function automatic logic [31:0] exp_data(logic [3:0] id);
    return (id == 4'd3) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | {28'h0, id});
  endfunction

  function automatic logic [3:0] exp_strb(logic [3:0] id);
    logic [3:0] one;
    one = 4'b0001;
    return (id == 4'd3) ? 4'hF : (one << id[1:0]);
  endfunction

  assign sq_rd_addr = exp_addr(sq_rd_id);
  assign sq_rd_data = exp_data(sq_rd_id) ^ salt;
  assign sq_rd_strb = exp_strb(sq_rd_id);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_if.mem_req_valid && mem_if.mem_req_ready) acc++;
    if (sq_release_valid) begin
      rel_q.push_back(sq_release_id);
      rel_t.push_back(cyc);
    end
    if (int'(drain_count) > peak) peak = int'(drain_count);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] id);
    rsv  = 1'b1;
    rsid = id;
    tick();
    rsv  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (!drain_idle && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(drain_idle), 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    logic [3:0] exp_ids [$];

    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    tick(2);
    chk("rst_idle", 32'(drain_idle), 32'd1);
    chk("rst_count", 32'(drain_count), 32'd0);
    chk("rst_req", 32'(mem_if.mem_req_valid), 32'd0);
    chk("rst_full", 32'(drain_full), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    chk("rst_addr", mem_if.mem_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // single store
    mem_if.mem_req_ready = 1'b1;
    push(4'd3);
    chk("s1_req0", 32'(mem_if.mem_req_valid), 32'd0);
    chk("s1_cnt1", 32'(drain_count), 32'd1);
    chk("s1_busy", 32'(drain_idle), 32'd0);
    chk("s1_rdid", 32'(sq_rd_id), 32'd3);
    tick();
    chk("s1_req1", 32'(mem_if.mem_req_valid), 32'd1);
    chk("s1_addr", mem_if.mem_addr, 32'h1000);
    chk("s1_data", mem_if.mem_wdata, 32'hDEAD_BEEF);
    chk("s1_strb", 32'(mem_if.mem_wstrb), 32'hF);
    tick();
    chk("s1_req_drop", 32'(mem_if.mem_req_valid), 32'd0);
    mem_if.mem_resp_valid = 1'b1;
    tick();
    mem_if.mem_resp_valid = 1'b0;
    chk("s1_rel", 32'(sq_release_valid), 32'd1);
    chk("s1_relid", 32'(sq_release_id), 32'd3);
    chk("s1_cnt0", 32'(drain_count), 32'd0);
    chk("s1_idle", 32'(drain_idle), 32'd1);
    tick();
    chk("s1_rel_end", 32'(sq_release_valid), 32'd0);

    // ready stall with changing store-queue contents
    mem_if.mem_req_ready = 1'b0;
    acc0 = acc;
    push(4'd5);
    tick();
    salt = 32'hFFFF_0000;
    for (int k = 0; k < 5; k++) begin
      chk("st_req", 32'(mem_if.mem_req_valid), 32'd1);
      chk("st_addr", mem_if.mem_addr, exp_addr(4'd5));
      chk("st_data", mem_if.mem_wdata, exp_data(4'd5));
      chk("st_strb", 32'(mem_if.mem_wstrb), 32'(exp_strb(4'd5)));
      tick();
    end
    salt = '0;
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    chk("st_req_drop", 32'(mem_if.mem_req_valid), 32'd0);
    mem_if.mem_resp_valid = 1'b1;
    tick();
    mem_if.mem_resp_valid = 1'b0;
    chk("st_relid", 32'(sq_release_id), 32'd5);
    tick();
    chk("st_accepts", 32'(acc - acc0), 32'd1);

    // ordering and back-to-back
    rel_q.delete();
    rel_t.delete();
    peak = 0;
    mem_if.mem_req_ready  = 1'b1;
    mem_if.mem_resp_valid = 1'b1;
    push(4'd1);
    push(4'd2);
    push(4'd3);
    wait_idle("ord_idle", 60);
    chk("ord_n", 32'(rel_q.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < rel_q.size()) chk("ord_id", 32'(rel_q[k]), 32'(k + 1));
    for (int k = 1; k < 3; k++)
      if (k < rel_t.size()) chk("ord_gap", 32'(rel_t[k] - rel_t[k-1]), 32'd4);
    chk("ord_peak", 32'(peak), 32'd3);

    // full, overflow, push+pop at full
    rel_q.delete();
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    for (int i = 0; i < 16; i++) push(4'(i));
    chk("full_flag", 32'(drain_full), 32'd1);
    chk("full_cnt", 32'(drain_count), 32'd16);
    chk("full_ovf0", 32'(overflow_err), 32'd0);
    push(4'd9);
    chk("ovf_set", 32'(overflow_err), 32'd1);
    chk("ovf_cnt", 32'(drain_count), 32'd16);
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b1;
    push(4'd10);
    mem_if.mem_resp_valid = 1'b0;
    chk("pp_cnt", 32'(drain_count), 32'd16);
    chk("pp_full", 32'(drain_full), 32'd1);
    chk("pp_relid", 32'(sq_release_id), 32'd0);
    mem_if.mem_req_ready  = 1'b1;
    mem_if.mem_resp_valid = 1'b1;
    wait_idle("full_idle", 200);
    exp_ids.delete();
    for (int i = 0; i < 16; i++) exp_ids.push_back(4'(i));
    exp_ids.push_back(4'd10);
    chk("full_nrel", 32'(rel_q.size()), 32'd17);
    for (int k = 0; k < 17; k++)
      if (k < rel_q.size()) chk("full_relid", 32'(rel_q[k]), 32'(exp_ids[k]));
    chk("ovf_sticky", 32'(overflow_err), 32'd1);

    // flush during REQ and WAIT_ACK
    rel_q.delete();
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    push(4'd4);
    push(4'd5);
    push(4'd6);
    flush = 1'b1;
    tick(2);
    chk("fl_req", 32'(mem_if.mem_req_valid), 32'd1);
    chk("fl_addr", mem_if.mem_addr, exp_addr(4'd4));
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    tick(2);
    chk("fl_wait_cnt", 32'(drain_count), 32'd3);
    mem_if.mem_req_ready  = 1'b1;
    mem_if.mem_resp_valid = 1'b1;
    wait_idle("fl_idle", 60);
    flush = 1'b0;
    chk("fl_nrel", 32'(rel_q.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < rel_q.size()) chk("fl_relid", 32'(rel_q[k]), 32'(k + 4));

    // reset in WAIT_ACK with four queued
    rel_q.delete();
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    push(4'd7);
    push(4'd8);
    push(4'd9);
    push(4'd10);
    chk("rs_req", 32'(mem_if.mem_req_valid), 32'd1);
    chk("rs_addr", mem_if.mem_addr, exp_addr(4'd7));
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    chk("rs_pre_cnt", 32'(drain_count), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("rs_req0", 32'(mem_if.mem_req_valid), 32'd0);
    chk("rs_cnt0", 32'(drain_count), 32'd0);
    chk("rs_idle", 32'(drain_idle), 32'd1);
    chk("rs_addr0", mem_if.mem_addr, 32'd0);
    chk("rs_ovf0", 32'(overflow_err), 32'd0);
    tick();
    rst_n = 1'b1;
    mem_if.mem_resp_valid = 1'b1;
    tick(3);
    mem_if.mem_resp_valid = 1'b0;
    tick();
    chk("rs_norel", 32'(rel_q.size()), 32'd0);
    chk("rs_cnt", 32'(drain_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
